// File: rtl/treasure_frame_sequencer.sv
// treasure_frame_sequencer: tracks camera frames, validates line counts and publishes
// debounced classifier codes over a RDY/ACK handshake.
module treasure_frame_sequencer #(
   parameter int CONFIRM_FRAMES = 3,
   parameter int EXP_LINES      = 144,
   parameter int LINE_TOL       = 2,
   parameter int SETTLE_CYCLES  = 4
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       ENABLE,
   input  logic       VSYNC,
   input  logic       HREF,
   input  logic [2:0] PROC_RESULT,
   input  logic       ACK,
   output logic       CAPTURE_EN,
   output logic       FRAME_ERR,
   output logic [2:0] TREASURE,
   output logic       RDY,
   output logic [7:0] FRAME_CNT
);
   typedef enum logic [2:0] {IDLE, ARM, ACTIVE, SETTLE, DECIDE} state_t;
   state_t state, state_nx;
   logic [3:0] vs_sh, hr_sh;
   logic [8:0] line_cnt;
   logic [3:0] settle_cnt;
   logic [2:0] cand;
   logic [3:0] match;
   logic vs_rise, vs_fall, href_rise, line_ok, confirmed;
   // two stable samples after two opposite ones: a single-sample glitch never matches
   assign vs_rise   = vs_sh == 4'b0011;
   assign vs_fall   = vs_sh == 4'b1100;
   assign href_rise = hr_sh == 4'b0011;
   assign line_ok   = line_cnt >= 9'(EXP_LINES - LINE_TOL) && line_cnt <= 9'(EXP_LINES + LINE_TOL);
   assign confirmed = match == 4'(CONFIRM_FRAMES);

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx   = state;
      CAPTURE_EN = 1'b0;
      FRAME_ERR  = 1'b0;
      if (!ENABLE) state_nx = IDLE;
      else
         case (state)
            IDLE:   state_nx = ARM;
            ARM:    state_nx = vs_fall ? ACTIVE : ARM;
            ACTIVE: begin
               CAPTURE_EN = !vs_rise;
               state_nx   = vs_rise ? SETTLE : ACTIVE;
            end
            SETTLE: state_nx = settle_cnt == 4'(SETTLE_CYCLES - 1) ? DECIDE : SETTLE;
            DECIDE: begin
               FRAME_ERR = !line_ok;
               state_nx  = ARM;
            end
            default: state_nx = IDLE;
         endcase
   end

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         vs_sh      <= '0;
         hr_sh      <= '0;
         line_cnt   <= '0;
         settle_cnt <= '0;
         cand       <= '0;
         match      <= '0;
         TREASURE   <= '0;
         RDY        <= 1'b0;
         FRAME_CNT  <= '0;
      end else begin
         vs_sh <= {vs_sh[2:0], VSYNC};
         hr_sh <= {hr_sh[2:0], HREF};
         if (state == ARM && vs_fall) line_cnt <= '0;
         else if (state == ACTIVE && href_rise && line_cnt != '1) line_cnt <= line_cnt + 9'd1;
         settle_cnt <= state == SETTLE ? settle_cnt + 4'd1 : '0;
         if (!ENABLE) begin
            cand  <= '0;
            match <= '0;
         end else if (state == DECIDE && line_ok) begin
            FRAME_CNT <= FRAME_CNT + 8'd1;
            cand      <= PROC_RESULT;
            match     <= PROC_RESULT != cand ? 4'd1 : confirmed ? match : match + 4'd1;
         end
         // TREASURE is frozen while the consumer still owes an ACK
         if (RDY) RDY <= !ACK;
         else if (confirmed && cand != TREASURE) begin
            TREASURE <= cand;
            RDY      <= 1'b1;
         end
      end
endmodule

// File: tb/tb_treasure_frame_sequencer.sv
// tb_treasure_frame_sequencer: directed camera frames checked every cycle against a
// frame-level model (sample history, vote queue, timestamps) plus hand-computed literals.
module tb_treasure_frame_sequencer;
   localparam int CONF = 3, EXP = 144, TOL = 2, SETTLE = 4;
   logic CLK = 1'b0, RST_N = 1'b0, ENABLE = 1'b1, VSYNC = 1'b1, HREF = 1'b0, ACK = 1'b0;
   logic [2:0] PROC_RESULT = '0;
   logic CAPTURE_EN, FRAME_ERR, RDY;
   logic [2:0] TREASURE;
   logic [7:0] FRAME_CNT;
   int tests = 0, fails = 0, err_seen = 0, cyc = 0;
   bit go = 0;

   treasure_frame_sequencer #(.CONFIRM_FRAMES(CONF), .EXP_LINES(EXP), .LINE_TOL(TOL), .SETTLE_CYCLES(SETTLE)) dut (
      .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .VSYNC(VSYNC), .HREF(HREF),
      .PROC_RESULT(PROC_RESULT), .ACK(ACK), .CAPTURE_EN(CAPTURE_EN), .FRAME_ERR(FRAME_ERR),
      .TREASURE(TREASURE), .RDY(RDY), .FRAME_CNT(FRAME_CNT)
   );

   always #5 CLK = ~CLK;

   // model: last four samples of each camera line (oldest first) and frame-level bookkeeping
   bit vh[$] = '{0, 0, 0, 0};
   bit hh[$] = '{0, 0, 0, 0};
   bit m_run, m_armed, m_in, m_rdy, m_vr, m_vf, m_hr, m_conf, m_dec;
   int m_lines = 0, m_close = -1;
   logic [2:0] m_tre = '0;
   logic [7:0] m_cnt = '0;
   logic [2:0] votes[$];

   function automatic bit pat(input bit a, input bit b, input bit c, input bit d, input bit v);
      return a == !v && b == !v && c == v && d == v;
   endfunction

   function automatic bit agreed();
      if (votes.size() < CONF) return 1'b0;
      foreach (votes[i]) if (votes[i] != votes[0]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit deciding();
      return m_close >= 0 && cyc == m_close + SETTLE + 1;
   endfunction

   function automatic bit lines_ok();
      return m_lines >= EXP - TOL && m_lines <= EXP + TOL;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         vh = '{0, 0, 0, 0};
         hh = '{0, 0, 0, 0};
         m_run = 0; m_armed = 0; m_in = 0; m_rdy = 0;
         m_lines = 0; m_close = -1; m_tre = '0; m_cnt = '0;
         votes.delete();
      end else begin
         m_vr   = pat(vh[0], vh[1], vh[2], vh[3], 1'b1);
         m_vf   = pat(vh[0], vh[1], vh[2], vh[3], 1'b0);
         m_hr   = pat(hh[0], hh[1], hh[2], hh[3], 1'b1);
         m_conf = agreed();
         m_dec  = deciding();
         if (m_rdy) m_rdy = !ACK;
         else if (m_conf && votes[$] != m_tre) begin
            m_tre = votes[$];
            m_rdy = 1;
         end
         if (!ENABLE) begin
            m_run = 0; m_armed = 0; m_in = 0; m_close = -1;
            votes.delete();
         end else if (!m_run) begin
            m_run = 1; m_armed = 1;
         end else if (m_armed) begin
            if (m_vf) begin
               m_armed = 0; m_in = 1; m_lines = 0;
            end
         end else if (m_in) begin
            if (m_hr && m_lines < 511) m_lines++;
            if (m_vr) begin
               m_in = 0; m_close = cyc;
            end
         end else if (m_dec) begin
            if (lines_ok()) begin
               m_cnt++;
               votes.push_back(PROC_RESULT);
               if (votes.size() > CONF) void'(votes.pop_front());
            end
            m_close = -1; m_armed = 1;
         end
         void'(vh.pop_front()); vh.push_back(VSYNC);
         void'(hh.pop_front()); hh.push_back(HREF);
         cyc++;
      end
   end

   always @(negedge CLK) if (go) begin
      chk("CAPTURE_EN", CAPTURE_EN, m_in && ENABLE && !pat(vh[0], vh[1], vh[2], vh[3], 1'b1));
      chk("FRAME_ERR", FRAME_ERR, deciding() && ENABLE && !lines_ok());
      chk("TREASURE", TREASURE, m_tre);
      chk("RDY", RDY, m_rdy);
      chk("FRAME_CNT", FRAME_CNT, m_cnt);
      if (FRAME_ERR) err_seen++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic line();
      HREF = 1; tick(2);
      HREF = 0; tick(2);
   endtask

   task automatic frame(input int lines, input logic [2:0] res, input int glitch_at = -1,
                        input int drop_at = -1, input logic [2:0] drop_t = '0, input bit drop_r = 0);
      VSYNC = 0;
      tick(4);
      for (int i = 0; i < lines; i++) begin
         if (i == glitch_at) begin
            VSYNC = 1; tick(1);
            VSYNC = 0; tick(2);
         end
         if (i == drop_at) begin
            @(negedge CLK);
            chk("drop_pre_capture", CAPTURE_EN, 1);
            tick(1);
            ENABLE = 0;
            tick(1);
            @(negedge CLK);
            chk("drop_capture", CAPTURE_EN, 0);
            chk("drop_treasure", TREASURE, drop_t);
            chk("drop_rdy", RDY, drop_r);
            tick(2);
            ENABLE = 1;
         end
         line();
      end
      tick(4);
      VSYNC = 1;
      PROC_RESULT = res;
      tick(14);
   endtask

   task automatic ack_pulse();
      ACK = 1; tick(1);
      ACK = 0;
      @(negedge CLK);
      chk("ack_rdy_low", RDY, 0);
      tick(1);
   endtask

   initial begin
      tick(3);
      RST_N = 1;
      go = 1;
      tick(8);
      repeat (3) frame(144, 3'b100);
      @(negedge CLK);
      chk("s1_cnt", FRAME_CNT, 3); chk("s1_treasure", TREASURE, 4); chk("s1_rdy", RDY, 1);
      tick(1);
      ack_pulse();
      frame(144, 3'b100); frame(144, 3'b100); frame(144, 3'b010); frame(144, 3'b010);
      @(negedge CLK);
      chk("s2_cnt_a", FRAME_CNT, 7); chk("s2_hold", TREASURE, 4); chk("s2_rdy_a", RDY, 0);
      frame(144, 3'b010);
      @(negedge CLK);
      chk("s2_cnt_b", FRAME_CNT, 8); chk("s2_treasure", TREASURE, 2); chk("s2_rdy_b", RDY, 1);
      frame(144, 3'b010);
      tick(1);
      ack_pulse();
      frame(140, 3'b001);
      @(negedge CLK);
      chk("s3_err_140", err_seen, 1); chk("s3_cnt_140", FRAME_CNT, 9);
      frame(520, 3'b001);
      @(negedge CLK);
      chk("s3_err_sat", err_seen, 2); chk("s3_cnt_sat", FRAME_CNT, 9);
      frame(142, 3'b010); frame(146, 3'b010);
      @(negedge CLK);
      chk("s3_cnt_ok", FRAME_CNT, 11); chk("s3_err_ok", err_seen, 2);
      chk("s3_treasure", TREASURE, 2); chk("s3_rdy", RDY, 0);
      repeat (3) frame(144, 3'b000);
      @(negedge CLK);
      chk("s4_gone", TREASURE, 0); chk("s4_rdy_a", RDY, 1); chk("s4_cnt_a", FRAME_CNT, 14);
      repeat (3) frame(144, 3'b001);
      @(negedge CLK);
      chk("s4_frozen", TREASURE, 0); chk("s4_rdy_b", RDY, 1); chk("s4_cnt_b", FRAME_CNT, 17);
      tick(1);
      ACK = 1; tick(1);
      ACK = 0;
      @(negedge CLK);
      chk("s4_rdy_fall", RDY, 0); chk("s4_still_old", TREASURE, 0);
      tick(1);
      @(negedge CLK);
      chk("s4_rdy_rise", RDY, 1); chk("s4_treasure", TREASURE, 1);
      tick(1);
      ack_pulse();
      frame(144, 3'b001, 70);
      @(negedge CLK);
      chk("s5_glitch_cnt", FRAME_CNT, 18); chk("s5_glitch_err", err_seen, 2);
      frame(144, 3'b001, -1, 50, 3'b001, 1'b0);
      frame(144, 3'b001);
      @(negedge CLK);
      chk("s5_cnt", FRAME_CNT, 19); chk("s5_treasure", TREASURE, 1); chk("s5_rdy", RDY, 0);
      tick(1);
      VSYNC = 0;
      tick(4);
      repeat (10) line();
      @(negedge CLK);
      chk("s6_pre_capture", CAPTURE_EN, 1);
      @(posedge CLK);
      #3 RST_N = 0;
      #1;
      chk("s6_rst_capture", CAPTURE_EN, 0); chk("s6_rst_err", FRAME_ERR, 0);
      chk("s6_rst_treasure", TREASURE, 0); chk("s6_rst_rdy", RDY, 0); chk("s6_rst_cnt", FRAME_CNT, 0);
      tick(2);
      RST_N = 1;
      repeat (20) line();
      tick(4);
      VSYNC = 1;
      tick(14);
      repeat (3) frame(144, 3'b100);
      @(negedge CLK);
      chk("s6_cnt", FRAME_CNT, 3); chk("s6_treasure", TREASURE, 4);
      chk("s6_rdy", RDY, 1); chk("s6_err", err_seen, 2);
      tick(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
